keypad_entry: RTL and testbench
===============================

# keypad_entry

Input-side counterpart of the multiplexed seven-segment display driver: scans a 4×4 hex keypad one column at a time, debounces presses, and assembles typed hex digits into a 32-bit word. The word feeds the same 8-digit display path and downstream consumers, such as MIPS test inputs. Each accepted key emits a one-cycle strobe.

## Interface
- SCAN_DIV, 1000: clock cycles each column is driven before advancing (≥4)
- DEBOUNCE_CNT, 20000: consecutive stable cycles required to accept a press or a release (≥2)
- clk  input  1  system clock
- clr  input  1  reset, synchronous, active-high
- row  input  4  keypad rows, active-low, externally pulled up, asynchronous
- col  output  4  keypad column drive, active-low, exactly one bit low at all times
- value  output  32  assembled word; the newest digit is in bits [3:0]
- key_valid  output  1  one-cycle strobe on each accepted press
- key_code  output  4  code of the last accepted key
- digits  output  4  count of accepted digits, saturating at 8

## Operation
- row passes through a 2-flop synchronizer; all logic uses the synchronized value rs.
- Key code = row_idx*4 + col_idx. Row and column indices run 0..3, with LSB = index 0.
- FSM states:
  - SCAN
    - Column index ci increments every SCAN_DIV cycles, wrapping 3→0.
    - col = ~(4'b0001 << ci).
    - rs is sampled only on the last cycle of each column slot.
    - Exactly one rs bit low: latch row_idx/col_idx, hold ci, go to PRESS_DB.
    - Zero bits low, or ≥2 bits low (ghosting or multi-press): stay in SCAN and keep scanning.
  - PRESS_DB
    - Column frozen.
    - Counter increments each cycle that rs equals the latched pattern.
    - Any mismatch returns to SCAN with counter cleared; ci resumes from the next column.
    - When the counter reaches DEBOUNCE_CNT: accept the key and go to HELD.
  - HELD
    - Column frozen.
    - Counter counts consecutive cycles with rs == 4'b1111; any low bit resets it to 0.
    - When it reaches DEBOUNCE_CNT: go to SCAN, ci advances.
- Accept action, all on a single clock edge:
  - value ← {value[27:0], code}
  - key_code ← code
  - key_valid = 1 for exactly that one cycle
  - digits ← min(digits+1, 8)
- value shifts without bound; the oldest digit falls off bits [31:28].
- Holding a key yields exactly one key_valid. Auto-repeat is not implemented.
- clr in any state, including mid-debounce or HELD, returns everything to reset values on the next edge. A key held through reset release is re-detected normally.

## Timing
- Reset values:
  - col = 4'b1110 (ci = 0)
  - value = 0, key_code = 0, key_valid = 0, digits = 0
  - state SCAN; both counters and the synchronizer at the idle value (4'b1111)
- Synchronizer latency: 2 cycles from a row pin change to rs.
- Press latency: key_valid asserts DEBOUNCE_CNT cycles after the PRESS_DB entry edge. value/key_code/digits update on the same edge that raises key_valid.
- col changes only on slot boundaries in SCAN, never in PRESS_DB/HELD.
- Counters are sized ceil(log2(max(SCAN_DIV, DEBOUNCE_CNT)+1)) bits. There is no wrap inside a state.
- clr takes priority over every other event on the same edge, including an accept edge. No key_valid is issued on that edge.

## Structure
- Package keypad_pkg:
  - state enum {SCAN, PRESS_DB, HELD}
  - ROW_IDLE = 4'b1111
  - function onehot_low_idx(rs) returning a valid flag plus a 2-bit index
- Sub-module sync2: parameterizable-width 2-flop synchronizer with synchronous clr preset to all ones. Instantiated once, for row.
- The rest is a single module: FSM, slot counter, debounce counter, shift register.

## Test plan
- Bench parameters: SCAN_DIV=4, DEBOUNCE_CNT=8. The keypad model pulls row[r] low when col[c] is low and key (r,c) is pressed.
- Reset then idle 200 cycles → col cycles 1110→1101→1011→0111→1110 every 4 cycles; value=0; key_valid never asserts.
- Press key (row 2, col 1), hold 100 cycles, release → exactly one key_valid; key_code=4'h9; value=32'h0000_0009; digits=1.
- Sequence of 9 keys: 1,2,3,4,5,6,7,8,A → value=32'h2345_678A; digits=8 (saturated).
- Bounce: press toggles every 3 cycles for 30 cycles, then held steady → no strobe during bouncing; exactly one key_valid, 8 stable cycles after settling.
- Two keys pressed in the same column → no key_valid; scanning continues. Releasing one key → the remaining key is accepted.
- clr asserted in the cycle before the accept edge (PRESS_DB counter at 7) → no key_valid; all outputs return to reset values; col=4'b1110 next cycle.

Source files
------------

// File: rtl/keypad_pkg.sv
// Shared types and helpers for the 4x4 hex keypad scanner.
// Row patterns are active-low: a pressed key pulls its row bit to 0.
package keypad_pkg;

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        PRESS_DB = 2'd1,
        HELD     = 2'd2
    } state_e;

    localparam logic [3:0] ROW_IDLE = 4'b1111;

    typedef struct packed {
        logic       valid;
        logic [1:0] idx;
    } onehot_t;

    // valid only when exactly one row bit is low; ghosting patterns are rejected
    function automatic onehot_t onehot_low_idx(input logic [3:0] rs);
        onehot_t res;
        res = '0;
        case (rs)
            4'b1110: res = '{valid: 1'b1, idx: 2'd0};
            4'b1101: res = '{valid: 1'b1, idx: 2'd1};
            4'b1011: res = '{valid: 1'b1, idx: 2'd2};
            4'b0111: res = '{valid: 1'b1, idx: 2'd3};
            default: res = '0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/keypad_entry_sync2.sv
// Two-flop synchronizer for asynchronous inputs; clr presets both stages to
// all ones, the idle level of the pulled-up keypad rows.
module sync2 #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         clr,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] meta_q;
    logic [W-1:0] sync_q;

    always_ff @(posedge clk) begin
        if (clr) begin
            meta_q <= '1;
            sync_q <= '1;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/keypad_entry.sv
// 4x4 hex keypad scanner with press/release debounce; accepted digits are
// shifted into a 32-bit word, newest digit in the low nibble.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// SCAN     | rotate the driven column, sample rows on the last slot cycle
// PRESS_DB | column frozen, count cycles the latched row pattern persists
// HELD     | key accepted, column frozen, count cycles of all rows idle
module keypad_entry
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV     = 1000,
    parameter int DEBOUNCE_CNT = 20000
) (
    input  logic        clk,
    input  logic        clr,
    input  logic [3:0]  row,
    output logic [3:0]  col,
    output logic [31:0] value,
    output logic        key_valid,
    output logic [3:0]  key_code,
    output logic [3:0]  digits
);

    localparam int CNT_MAX = (SCAN_DIV > DEBOUNCE_CNT) ? SCAN_DIV : DEBOUNCE_CNT;
    localparam int CW      = $clog2(CNT_MAX + 1);

    localparam logic [CW-1:0] SLOT_LAST = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] DB_LAST   = CW'(DEBOUNCE_CNT - 1);

    logic [3:0] rs;

    state_e        state_q, state_d;
    logic [1:0]    ci_q, ci_d;
    logic [CW-1:0] slot_q, slot_d;
    logic [CW-1:0] db_q, db_d;
    logic [3:0]    pat_q, pat_d;
    logic [1:0]    ridx_q, ridx_d;
    logic [31:0]   value_q, value_d;
    logic [3:0]    code_q, code_d;
    logic          kv_q, kv_d;
    logic [3:0]    digits_q, digits_d;

    onehot_t    hit;
    logic [3:0] new_code;

    sync2 #(.W(4)) u_row_sync (
        .clk (clk),
        .clr (clr),
        .d_i (row),
        .q_o (rs)
    );

    assign hit      = onehot_low_idx(rs);
    assign new_code = {ridx_q, ci_q};

    always_comb begin
        state_d  = state_q;
        ci_d     = ci_q;
        slot_d   = slot_q;
        db_d     = db_q;
        pat_d    = pat_q;
        ridx_d   = ridx_q;
        value_d  = value_q;
        code_d   = code_q;
        kv_d     = 1'b0;
        digits_d = digits_q;

        case (state_q)
            SCAN: begin
                if (slot_q == '0) begin
                    slot_d = SLOT_LAST;
                    if (hit.valid) begin
                        state_d = PRESS_DB;
                        pat_d   = rs;
                        ridx_d  = hit.idx;
                        db_d    = '0;
                    end else begin
                        ci_d = ci_q + 2'd1;
                    end
                end else begin
                    slot_d = slot_q - 1'b1;
                end
            end

            PRESS_DB: begin
                if (rs == pat_q) begin
                    if (db_q == DB_LAST) begin
                        state_d  = HELD;
                        db_d     = '0;
                        value_d  = {value_q[27:0], new_code};
                        code_d   = new_code;
                        kv_d     = 1'b1;
                        digits_d = (digits_q == 4'd8) ? 4'd8 : digits_q + 4'd1;
                    end else begin
                        db_d = db_q + 1'b1;
                    end
                end else begin
                    // bounce: give up on this column and resume the rotation
                    state_d = SCAN;
                    db_d    = '0;
                    ci_d    = ci_q + 2'd1;
                    slot_d  = SLOT_LAST;
                end
            end

            HELD: begin
                if (rs == ROW_IDLE) begin
                    if (db_q == DB_LAST) begin
                        state_d = SCAN;
                        db_d    = '0;
                        ci_d    = ci_q + 2'd1;
                        slot_d  = SLOT_LAST;
                    end else begin
                        db_d = db_q + 1'b1;
                    end
                end else begin
                    db_d = '0;
                end
            end

            default: begin
                state_d = SCAN;
                db_d    = '0;
                slot_d  = SLOT_LAST;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q  <= SCAN;
            ci_q     <= 2'd0;
            slot_q   <= SLOT_LAST;
            db_q     <= '0;
            pat_q    <= ROW_IDLE;
            ridx_q   <= 2'd0;
            value_q  <= 32'd0;
            code_q   <= 4'd0;
            kv_q     <= 1'b0;
            digits_q <= 4'd0;
        end else begin
            state_q  <= state_d;
            ci_q     <= ci_d;
            slot_q   <= slot_d;
            db_q     <= db_d;
            pat_q    <= pat_d;
            ridx_q   <= ridx_d;
            value_q  <= value_d;
            code_q   <= code_d;
            kv_q     <= kv_d;
            digits_q <= digits_d;
        end
    end

    assign col       = ~(4'b0001 << ci_q);
    assign value     = value_q;
    assign key_valid = kv_q;
    assign key_code  = code_q;
    assign digits    = digits_q;

endmodule

// File: tb/tb_keypad_entry.sv
// Directed and randomized keypad sessions against a digit-history model of
// the entry word, with a physical keypad model closing the row/column loop.
module tb_keypad_entry;

    localparam int SCAN_DIV     = 4;
    localparam int DEBOUNCE_CNT = 8;
    localparam int LATENCY      = SCAN_DIV + DEBOUNCE_CNT;

    logic        clk = 1'b0;
    logic        clr = 1'b1;
    logic [3:0]  row;
    logic [3:0]  col;
    logic [31:0] value;
    logic        key_valid;
    logic [3:0]  key_code;
    logic [3:0]  digits;

    logic [15:0] pressed = '0;

    int n_cmp = 0;
    int n_mis = 0;

    int cyc      = 0;
    int since    = 0;
    int kv_cnt   = 0;
    int kv_since = 0;
    int kv_cyc   = 0;
    int col_chg  = 0;
    logic [3:0] prev_col = 4'b1110;

    logic [31:0] exp_value  = '0;
    int          exp_digits = 0;

    keypad_entry #(
        .SCAN_DIV     (SCAN_DIV),
        .DEBOUNCE_CNT (DEBOUNCE_CNT)
    ) dut (
        .clk       (clk),
        .clr       (clr),
        .row       (row),
        .col       (col),
        .value     (value),
        .key_valid (key_valid),
        .key_code  (key_code),
        .digits    (digits)
    );

    always #5 clk = ~clk;

    // key (r,c) shorts row r to column c; rows are pulled up otherwise
    always_comb begin
        row = 4'b1111;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (pressed[r*4 + c] && !col[c]) row[r] = 1'b0;
    end

    always @(posedge clk) begin
        #1;
        cyc++;
        if (col !== prev_col) begin
            since = 0;
            col_chg++;
        end else begin
            since++;
        end
        prev_col = col;
        if (key_valid === 1'b1) begin
            kv_cnt++;
            kv_since = since;
            kv_cyc   = cyc;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_mis++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_accept(input int code);
        exp_value  = (exp_value << 4) | 32'(code);
        exp_digits = (exp_digits >= 8) ? 8 : exp_digits + 1;
    endtask

    task automatic check_outputs(input string tag, input int code);
        chk({tag, " key_code"}, 32'(key_code), 32'(code));
        chk({tag, " value"}, value, exp_value);
        chk({tag, " digits"}, 32'(digits), 32'(exp_digits));
    endtask

    task automatic press_key(input string tag, input int code, input int hold, input int gap);
        int k0;
        k0 = kv_cnt;
        pressed[code] = 1'b1;
        tick(hold);
        pressed[code] = 1'b0;
        tick(gap);
        model_accept(code);
        chk({tag, " strobes"}, 32'(kv_cnt - k0), 32'd1);
        chk({tag, " latency"}, 32'(kv_since), 32'(LATENCY));
        check_outputs(tag, code);
    endtask

    initial begin
        int errs;
        int run;
        int changes;
        int k0;
        int chg0;
        int settle;
        int found;
        logic [3:0] pc;
        int seq [9] = '{1, 2, 3, 4, 5, 6, 7, 8, 10};

        // reset state
        tick(3);
        chk("reset col", 32'(col), 32'h0000_000E);
        chk("reset value", value, 32'd0);
        chk("reset key_code", 32'(key_code), 32'd0);
        chk("reset key_valid", 32'(key_valid), 32'd0);
        chk("reset digits", 32'(digits), 32'd0);
        clr = 1'b0;

        // idle scanning: rotation order and slot length
        errs = 0; run = 0; changes = 0; k0 = kv_cnt;
        pc = col;
        for (int i = 0; i < 200; i++) begin
            tick(1);
            if (col !== pc) begin
                if (col !== {pc[2:0], pc[3]}) errs++;
                if (changes > 0 && run != SCAN_DIV) errs++;
                changes++;
                run = 1;
                pc  = col;
            end else begin
                run++;
            end
        end
        chk("idle rotation errors", 32'(errs), 32'd0);
        chk("idle enough changes", 32'(changes >= 45), 32'd1);
        chk("idle no strobe", 32'(kv_cnt - k0), 32'd0);
        chk("idle value", value, 32'd0);

        // single key (row 2, col 1) held long
        press_key("key9", 9, 100, 30);
        chk("key9 value literal", value, 32'h0000_0009);

        // nine-key sequence saturates digits
        foreach (seq[i]) press_key("seq", seq[i], 40, 20);
        chk("seq value literal", value, 32'h2345_678A);
        chk("seq digits literal", 32'(digits), 32'd8);

        // bouncing contact on key 5 (row 1, col 1)
        k0 = kv_cnt;
        for (int p = 0; p < 10; p++) begin
            pressed[5] = (p % 2 == 0);
            tick(3);
        end
        chk("bounce no strobe", 32'(kv_cnt - k0), 32'd0);
        pressed[5] = 1'b1;
        settle = cyc;
        tick(50);
        pressed[5] = 1'b0;
        tick(25);
        model_accept(5);
        chk("bounce strobes", 32'(kv_cnt - k0), 32'd1);
        chk("bounce settle gap", 32'(kv_cyc - settle >= DEBOUNCE_CNT + 2), 32'd1);
        chk("bounce latency", 32'(kv_since), 32'(LATENCY));
        check_outputs("bounce", 5);

        // two keys in column 2: rejected until one lets go
        k0 = kv_cnt; chg0 = col_chg;
        pressed[2]  = 1'b1;
        pressed[14] = 1'b1;
        tick(60);
        chk("ghost no strobe", 32'(kv_cnt - k0), 32'd0);
        chk("ghost still scanning", 32'(col_chg - chg0 >= 10), 32'd1);
        pressed[2] = 1'b0;
        tick(40);
        pressed[14] = 1'b0;
        tick(25);
        model_accept(14);
        chk("ghost strobes", 32'(kv_cnt - k0), 32'd1);
        check_outputs("ghost", 14);

        // clr one cycle before the accept edge; key stays held through reset
        k0 = kv_cnt; found = 0;
        pressed[7] = 1'b1;
        for (int i = 0; i < 100 && found == 0; i++) begin
            tick(1);
            if (since == LATENCY - 1) found = 1;
        end
        chk("clr window reached", 32'(found), 32'd1);
        clr = 1'b1;
        tick(1);
        exp_value = '0; exp_digits = 0;
        chk("clr no strobe", 32'(kv_cnt - k0), 32'd0);
        chk("clr key_valid", 32'(key_valid), 32'd0);
        chk("clr col", 32'(col), 32'h0000_000E);
        check_outputs("clr", 0);
        clr = 1'b0;
        tick(40);
        pressed[7] = 1'b0;
        tick(25);
        model_accept(7);
        chk("redetect strobes", 32'(kv_cnt - k0), 32'd1);
        chk("redetect latency", 32'(kv_since), 32'(LATENCY));
        check_outputs("redetect", 7);

        // randomized typing session
        for (int i = 0; i < 12; i++)
            press_key("rand", int'($urandom_range(15)), int'($urandom_range(70, 35)),
                      int'($urandom_range(40, 15)));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
